game_flow_ctrl: RTL and testbench

- Top-level game sequencer for the player-ball datapath.
- Runs the frame-rate state machine MENU / PLAYING / PAUSED / DYING / OVER, and drives current_state_out and die into the ball modules.
- Tracks lives and a survival score.
- Consumes the keycode bitmask from the USB keyboard path and a collision flag from the collision detector.

---
 rtl/game_flow_ctrl.sv | 141 ++++++++++++++
 tb/tb_game_flow_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Frame-rate game sequencer: MENU / PLAYING / PAUSED / DYING / OVER, with lives,
// survival score and a respawn hold (die) for the ball modules.
module game_flow_ctrl #(
    parameter int LIVES          = 3,
    parameter int RESPAWN_FRAMES = 60,
    parameter int SCORE_W        = 16
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_tick,
    input  logic [7:0]         keycode,
    input  logic               hit,
    output logic [1:0]         current_state_out,
    output logic               die,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] score
);

    localparam int TW = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;

    localparam logic [1:0] OUT_MENU    = 2'd0;
    localparam logic [1:0] OUT_PLAYING = 2'd1;
    localparam logic [1:0] OUT_FROZEN  = 2'd2;
    localparam logic [1:0] OUT_OVER    = 2'd3;

    typedef enum logic [2:0] {
        ST_MENU,
        ST_PLAYING,
        ST_PAUSED,
        ST_DYING,
        ST_OVER
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               key_prev_q, key_prev_d;
    logic [1:0]         cso_q, cso_d;
    logic               die_q, die_d;
    logic               press;
    logic               unused_keys;

    // Only bit0 is a game control; the rest of the bitmask belongs to other consumers.
    assign unused_keys = ^keycode[7:1];
    assign press       = keycode[0] & ~key_prev_q;

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        score_d    = score_q;
        timer_d    = timer_q;
        key_prev_d = key_prev_q;

        if (frame_tick) begin
            key_prev_d = keycode[0];
            case (state_q)
                ST_MENU: begin
                    if (press) begin
                        state_d = ST_PLAYING;
                        lives_d = 2'(LIVES);
                        score_d = '0;
                    end
                end
                ST_PLAYING: begin
                    // A hit wins over a simultaneous press; that press is still consumed.
                    if (hit) begin
                        state_d = ST_DYING;
                        lives_d = lives_q - 2'd1;
                        timer_d = TW'(RESPAWN_FRAMES - 1);
                    end else if (press) begin
                        state_d = ST_PAUSED;
                    end else if (score_q != {SCORE_W{1'b1}}) begin
                        score_d = score_q + 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (press) begin
                        state_d = ST_PLAYING;
                    end
                end
                ST_DYING: begin
                    if (timer_q == '0) begin
                        state_d = (lives_q == 2'd0) ? ST_OVER : ST_PLAYING;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_OVER: begin
                    if (press) begin
                        state_d = ST_MENU;
                    end
                end
                default: state_d = ST_MENU;
            endcase
        end
    end

    // Ball-facing outputs are decoded from the next state so they land on the same edge.
    always_comb begin
        cso_d = OUT_MENU;
        die_d = 1'b0;
        case (state_d)
            ST_MENU:    cso_d = OUT_MENU;
            ST_PLAYING: cso_d = OUT_PLAYING;
            ST_PAUSED:  cso_d = OUT_FROZEN;
            ST_DYING: begin
                cso_d = OUT_FROZEN;
                die_d = 1'b1;
            end
            ST_OVER:    cso_d = OUT_OVER;
            default:    cso_d = OUT_MENU;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_MENU;
            lives_q    <= 2'd0;
            score_q    <= '0;
            timer_q    <= '0;
            key_prev_q <= 1'b1;
            cso_q      <= OUT_MENU;
            die_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            score_q    <= score_d;
            timer_q    <= timer_d;
            key_prev_q <= key_prev_d;
            cso_q      <= cso_d;
            die_q      <= die_d;
        end
    end

    assign current_state_out = cso_q;
    assign die               = die_q;
    assign lives             = lives_q;
    assign score             = score_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed vector table, async-reset corner case,
// then random keys/hits checked against a frame-level reference model.
module tb_game_flow_ctrl;

    localparam int LIVES   = 3;
    localparam int RESP    = 4;
    localparam int SW      = 4;
    localparam int SMAX    = (1 << SW) - 1;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          frame_tick = 1'b0;
    logic [7:0]    keycode = 8'h01;
    logic          hit = 1'b0;
    logic [1:0]    current_state_out;
    logic          die;
    logic [1:0]    lives;
    logic [SW-1:0] score;

    game_flow_ctrl #(.LIVES(LIVES), .RESPAWN_FRAMES(RESP), .SCORE_W(SW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .keycode(keycode),
        .hit(hit), .current_state_out(current_state_out), .die(die),
        .lives(lives), .score(score)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: game phase plus "frames of dwell still to serve".
    typedef enum int {M_MENU, M_PLAY, M_PAUSE, M_DYING, M_OVER} mphase_e;
    mphase_e m_phase;
    int      m_lives, m_score, m_left;
    bit      m_prev;

    typedef struct {
        logic [7:0] kc;
        logic       h;
        int         cso;
        int         die;
        int         lv;
        int         sc;
    } vec_t;
    vec_t vq[$];

    task automatic cmp(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int e_cso, input int e_die,
                             input int e_lv, input int e_sc);
        cmp({tag, ".state"}, int'(current_state_out), e_cso);
        cmp({tag, ".die"},   int'(die),               e_die);
        cmp({tag, ".lives"}, int'(lives),             e_lv);
        cmp({tag, ".score"}, int'(score),             e_sc);
    endtask

    task automatic model_reset();
        m_phase = M_MENU; m_lives = 0; m_score = 0; m_left = 0; m_prev = 1'b1;
    endtask

    task automatic model_step(input bit key, input bit h);
        bit press;
        press  = key && !m_prev;
        m_prev = key;
        case (m_phase)
            M_MENU:  if (press) begin m_phase = M_PLAY; m_lives = LIVES; m_score = 0; end
            M_PLAY: begin
                if (h) begin m_phase = M_DYING; m_lives--; m_left = RESP; end
                else if (press) m_phase = M_PAUSE;
                else if (m_score < SMAX) m_score++;
            end
            M_PAUSE: if (press) m_phase = M_PLAY;
            M_DYING: begin
                m_left--;
                if (m_left == 0) m_phase = (m_lives == 0) ? M_OVER : M_PLAY;
            end
            M_OVER:  if (press) m_phase = M_MENU;
            default: m_phase = M_MENU;
        endcase
    endtask

    function automatic int m_cso();
        case (m_phase)
            M_MENU:  return 0;
            M_PLAY:  return 1;
            M_PAUSE: return 2;
            M_DYING: return 2;
            default: return 3;
        endcase
    endfunction

    // One idle cycle with junk inputs (must be ignored), then one frame_tick cycle.
    task automatic do_tick(input logic [7:0] kc, input logic h);
        @(negedge Clk);
        keycode = 8'($urandom);
        hit     = 1'($urandom);
        @(negedge Clk);
        keycode    = kc;
        hit        = h;
        frame_tick = 1'b1;
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
        model_step(kc[0], h);
    endtask

    task automatic addv(input logic [7:0] kc, input logic h, input int c, input int d,
                        input int l, input int s);
        vec_t v;
        v.kc = kc; v.h = h; v.cso = c; v.die = d; v.lv = l; v.sc = s;
        vq.push_back(v);
    endtask

    initial begin
        // Directed table: key held through reset, play, pause, deaths, game over, saturation.
        for (int i = 0; i < 3; i++) addv(8'h01, 1'b0, 0, 0, 0, 0);
        addv(8'h00, 1'b0, 0, 0, 0, 0);
        addv(8'h01, 1'b1, 1, 0, 3, 0);
        for (int i = 1; i <= 10; i++) addv(8'h00, 1'b0, 1, 0, 3, i);
        addv(8'h01, 1'b0, 2, 0, 3, 10);
        for (int i = 0; i < 5; i++) addv(8'h00, 1'b1, 2, 0, 3, 10);
        addv(8'h01, 1'b0, 1, 0, 3, 10);
        addv(8'h00, 1'b1, 2, 1, 2, 10);
        for (int i = 0; i < RESP - 1; i++) addv(8'h00, 1'b0, 2, 1, 2, 10);
        addv(8'h00, 1'b0, 1, 0, 2, 10);
        addv(8'h00, 1'b0, 1, 0, 2, 11);
        addv(8'h01, 1'b1, 2, 1, 1, 11);
        addv(8'h00, 1'b0, 2, 1, 1, 11);
        addv(8'h01, 1'b1, 2, 1, 1, 11);
        addv(8'h00, 1'b0, 2, 1, 1, 11);
        addv(8'h00, 1'b0, 1, 0, 1, 11);
        addv(8'h00, 1'b1, 2, 1, 0, 11);
        for (int i = 0; i < RESP - 1; i++) addv(8'h00, 1'b0, 2, 1, 0, 11);
        addv(8'h00, 1'b0, 3, 0, 0, 11);
        addv(8'h00, 1'b1, 3, 0, 0, 11);
        addv(8'h01, 1'b0, 0, 0, 0, 11);
        addv(8'h00, 1'b1, 0, 0, 0, 11);
        addv(8'hFF, 1'b0, 1, 0, 3, 0);
        addv(8'hFE, 1'b0, 1, 0, 3, 1);
        for (int i = 2; i <= 20; i++) addv(8'h00, 1'b0, 1, 0, 3, (i < SMAX) ? i : SMAX);

        model_reset();
        repeat (3) @(negedge Clk);
        check_all("reset", 0, 0, 0, 0);
        Reset_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            do_tick(vq[i].kc, vq[i].h);
            check_all($sformatf("vec%0d", i), vq[i].cso, vq[i].die, vq[i].lv, vq[i].sc);
        end

        // Reset asserted asynchronously in the middle of a DYING dwell.
        do_tick(8'h00, 1'b1);
        check_all("pre_rst_dying", 2, 1, 2, 15);
        do_tick(8'h00, 1'b0);
        @(negedge Clk);
        keycode = 8'h01;
        #2 Reset_n = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 0);
        model_reset();
        @(negedge Clk);
        Reset_n = 1'b1;
        do_tick(8'h01, 1'b0);
        check_all("held_after_rst", 0, 0, 0, 0);
        do_tick(8'h00, 1'b0);
        do_tick(8'h01, 1'b0);
        check_all("start_after_rst", 1, 0, 3, 0);

        // Random play against the reference model.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] kc;
            logic       h;
            kc = 8'($urandom);
            h  = ($urandom_range(0, 7) == 0);
            do_tick(kc, h);
            check_all($sformatf("rand%0d", i), m_cso(), (m_phase == M_DYING) ? 1 : 0,
                      m_lives, m_score);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
